multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the RV32I datapath over a single shared instruction/data memory port.
- Generates per-state enables: instruction fetch, IR load, memory access, register write-back and PC update.
- Supports six opcode classes: OP_IMM, OP, JAL, BRANCH, LOAD, STORE.
- Sits beside the combinational control decoder and owns all datapath write enables.

Parameters:
CNT_W, 32, width of retired-instruction counter instret
TIMEOUT, 255, cycles mem_ready may stay low in FETCH/MEM before fault; 0 disables timeout

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
run  input  1  level enable; sampled in IDLE and at each instruction boundary
opcode  input  7  instruction[6:0] from IR; valid from DECODE onward
take_branch  input  1  ALU branch-compare result; valid in EXEC
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  memory write (store); only with mem_req
addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result
ir_we  output  1  load IR from memory read data
pc_we  output  1  PC update
pc_sel  output  1  PC source: 0 = PC+4, 1 = ALU target
reg_we  output  1  register-file write
wb_sel  output  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+4
busy  output  1  state is not IDLE and not HALT
fault  output  1  sticky; illegal opcode or memory timeout
state  output  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - instret=0, fault=0.
  - Internal class register and wait counter cleared.
  - All outputs 0.
  - Reset mid-instruction abandons the instruction with no partial retire.
- Outputs are combinational from state, latched class, mem_ready and take_branch. Each enable is 0 unless stated below.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - mem_req=1, addr_sel=0.
  - ir_we = mem_ready.
  - mem_ready=1 -> DECODE.
- DECODE:
  - Latch class from the full 7-bit opcode: 0010011 OP_IMM, 0110011 OP, 1101111 JAL, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE.
  - Any other opcode -> HALT with fault=1.
  - Otherwise -> EXEC.
- EXEC:
  - OP, OP_IMM, JAL -> WB.
  - LOAD, STORE -> MEM.
  - BRANCH: pc_we=1, pc_sel=take_branch; retire; go to boundary.
- MEM:
  - mem_req=1, addr_sel=1, mem_we = (class==STORE).
  - On mem_ready: LOAD -> WB; STORE -> pc_we=1, pc_sel=0, retire, boundary.
- WB:
  - reg_we=1.
  - wb_sel = 01 for LOAD, 10 for JAL, 00 otherwise.
  - pc_we=1, pc_sel = (class==JAL).
  - Retire; boundary.
- Boundary: next state is FETCH if run=1, else IDLE. run is only sampled here and in IDLE, so deasserting run never aborts an instruction.
- Retire: instret increments by 1 in the retiring cycle; wraps modulo 2^CNT_W.
- Latency (mem_ready=1 at first request):
  - BRANCH: 3 cycles.
  - OP, OP_IMM, JAL: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM.
  - Counter increments each cycle in FETCH/MEM with mem_ready=0.
  - When the counter reaches TIMEOUT with mem_ready still 0 -> HALT, fault=1.
  - mem_ready on the same cycle the counter reaches TIMEOUT wins: the access completes normally.
- HALT:
  - All enables 0, busy=0, fault=1.
  - Exits only by rst; run is ignored.
- mem_we is never 1 while addr_sel=0; pc_we and ir_we are never 1 in the same cycle.

Test Plan:
- Reset, run=1, opcode=0010011, mem_ready=1 -> states 1,2,3,5,1; WB cycle shows reg_we=1, wb_sel=00, pc_we=1, pc_sel=0; instret=1.
- LOAD (0000011) with mem_ready low for 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 held 4 cycles; then WB with wb_sel=01; instret increments once.
- BRANCH (1100011) with take_branch=1, then again with take_branch=0 -> EXEC pc_we=1, pc_sel=1 then 0; reg_we never 1; 3 cycles per instruction.
- JAL (1101111) -> WB: reg_we=1, wb_sel=10, pc_sel=1. STORE (0100011) -> MEM: mem_we=1, then FETCH with no reg_we.
- opcode=1111111 -> HALT, fault=1, busy=0; run toggling does not leave HALT; rst returns IDLE with fault=0.
- TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles; separately, assert rst during MEM -> outputs 0 immediately and instret unchanged.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer. A small FSM walks each instruction through
// FETCH / DECODE / EXEC / MEM / WB over one shared memory port and owns every
// datapath write enable. A wait counter bounds how long a memory access may
// stall, and an illegal opcode or a stalled access parks the FSM in HALT with
// a sticky fault that only reset clears.
module multicycle_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             take_branch,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  // FSM encoding is visible on the state port, so it is fixed.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  // Internal opcode class, latched in DECODE so later states do not depend
  // on the IR contents staying put.
  localparam logic [2:0] CL_OPIMM  = 3'd0;
  localparam logic [2:0] CL_OP     = 3'd1;
  localparam logic [2:0] CL_JAL    = 3'd2;
  localparam logic [2:0] CL_BRANCH = 3'd3;
  localparam logic [2:0] CL_LOAD   = 3'd4;
  localparam logic [2:0] CL_STORE  = 3'd5;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // The wait counter only needs to hold 0..TIMEOUT-1: the cycle that would
  // carry it to TIMEOUT is the cycle that faults instead.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic [2:0]       cls_q, cls_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             fault_q, fault_d;

  logic             retire;
  logic             tmo_hit;
  logic             op_legal;
  logic [2:0]       op_cls;
  logic [2:0]       bound_st;

  // Classify the raw opcode; anything outside the six supported classes is illegal.
  always_comb begin
    op_legal = 1'b1;
    op_cls   = CL_OPIMM;
    case (opcode)
      OPC_OPIMM:  op_cls = CL_OPIMM;
      OPC_OP:     op_cls = CL_OP;
      OPC_JAL:    op_cls = CL_JAL;
      OPC_BRANCH: op_cls = CL_BRANCH;
      OPC_LOAD:   op_cls = CL_LOAD;
      OPC_STORE:  op_cls = CL_STORE;
      default:    op_legal = 1'b0;
    endcase
  end

  // A ready arriving on the last allowed cycle wins over the timeout.
  assign tmo_hit  = (TIMEOUT != 0) && (wait_q == WAIT_LAST) && !mem_ready;
  // run is only looked at here (and in IDLE), so dropping it mid-instruction
  // lets the current instruction finish.
  assign bound_st = run ? ST_FETCH : ST_IDLE;

  // Next-state, class latch, wait counter and retire strobe.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    fault_d = fault_q;
    wait_d  = '0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        if (op_legal) begin
          cls_d   = op_cls;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_BRANCH: begin
            retire  = 1'b1;
            state_d = bound_st;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (cls_q == CL_STORE) begin
            retire  = 1'b1;
            state_d = bound_st;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_hit) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = bound_st;
      end
      ST_HALT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

  // State registers; reset abandons any instruction in flight without retiring it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cls_q     <= CL_OPIMM;
      wait_q    <= '0;
      instret_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
    end
  end

  // Per-state datapath enables, decoded from the current state and latched class.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      ST_EXEC: begin
        if (cls_q == CL_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = take_branch;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == CL_STORE);
        pc_we    = mem_ready && (cls_q == CL_STORE);
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_sel = (cls_q == CL_JAL);
        case (cls_q)
          CL_LOAD: wb_sel = WB_MEM;
          CL_JAL:  wb_sel = WB_PC4;
          default: wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign fault   = fault_q;
  assign state   = state_q;
  assign instret = instret_q;

`ifndef SYNTHESIS
  // Stores only ever target the ALU address, and PC/IR never update together.
  a_we_addr: assert property (@(posedge clk) disable iff (rst) !(mem_we && !addr_sel));
  a_pc_ir:   assert property (@(posedge clk) disable iff (rst) !(pc_we && ir_we));
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle output trace and queues it; a
// monitor pops one entry per cycle and compares it against the DUT.
module tb_multicycle_sequencer;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [6:0] opcode = '0;
  logic take_branch = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, busy, fault;
  logic [1:0] wb_sel;
  logic [2:0] state;
  logic [CW-1:0] instret;

  multicycle_sequencer #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .take_branch(take_branch),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .busy(busy), .fault(fault), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we;
    logic [1:0]    wb_sel;
    logic          busy, fault;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_ret = 0;
  bit   need_reset = 0;
  bit   need_start = 0;
  logic [6:0] legal_ops [6] = '{7'b0010011, 7'b0110011, 7'b1101111,
                                7'b1100011, 7'b0000011, 7'b0100011};

  // Instruction class per the opcode table: 0 OP_IMM, 1 OP, 2 JAL,
  // 3 BRANCH, 4 LOAD, 5 STORE, -1 illegal.
  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0010011: return 0;
      7'b0110011: return 1;
      7'b1101111: return 2;
      7'b1100011: return 3;
      7'b0000011: return 4;
      7'b0100011: return 5;
      default:    return -1;
    endcase
  endfunction

  function automatic logic rb();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  // Baseline expectation for a state: everything off, busy outside IDLE/HALT,
  // fault exactly while halted, retired count modulo 2^CW.
  function automatic exp_t E(input logic [2:0] st);
    exp_t e;
    e       = '0;
    e.st    = st;
    e.busy  = (st != 3'd0) && (st != 3'd6);
    e.fault = (st == 3'd6);
    e.ret   = CW'(exp_ret);
    return e;
  endfunction

  task automatic cyc(input logic r, input logic rn, input logic [6:0] op,
                     input logic tbv, input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; run = rn; opcode = op; take_branch = tbv; mem_ready = rdy;
    q.push_back(e);
  endtask

  task automatic halt_cycles(input logic [6:0] op);
    for (int i = 0; i < 3; i++) cyc(1'b0, rb(), op, rb(), rb(), E(3'd6));
    need_reset = 1;
  endtask

  task automatic do_reset();
    exp_ret = 0;
    cyc(1'b1, rb(), 7'd0, rb(), rb(), E(3'd0));
  endtask

  task automatic start();
    cyc(1'b0, 1'b0, 7'd0, rb(), rb(), E(3'd0));
    cyc(1'b0, 1'b1, 7'd0, rb(), rb(), E(3'd0));
  endtask

  task automatic recover();
    if (need_reset) do_reset();
    if (need_reset || need_start) start();
    need_reset = 0;
    need_start = 0;
  endtask

  // One instruction starting in FETCH. fw/mw are the stall cycles before
  // mem_ready in fetch/memory; a stall of TMO or more means a timeout.
  task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic tbv,
                       input logic run_after, input int idle_n, input bit rst_mid);
    exp_t e;
    int   cls;
    cls = classify(op);
    for (int i = 0; i < fw && i < TMO; i++) begin
      e = E(3'd1); e.mem_req = 1'b1;
      cyc(1'b0, rb(), op, rb(), 1'b0, e);
    end
    if (fw >= TMO) begin halt_cycles(op); return; end
    e = E(3'd1); e.mem_req = 1'b1; e.ir_we = 1'b1;
    cyc(1'b0, rb(), op, rb(), 1'b1, e);
    cyc(1'b0, rb(), op, rb(), rb(), E(3'd2));
    if (cls < 0) begin halt_cycles(op); return; end
    e = E(3'd3);
    if (cls == 3) begin
      e.pc_we = 1'b1; e.pc_sel = tbv;
      cyc(1'b0, run_after, op, tbv, rb(), e);
      exp_ret++;
    end else begin
      cyc(1'b0, rb(), op, rb(), rb(), e);
    end
    if (cls == 4 || cls == 5) begin
      for (int i = 0; i < mw && i < TMO; i++) begin
        e = E(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (cls == 5);
        cyc(1'b0, rb(), op, rb(), 1'b0, e);
        if (rst_mid) begin
          do_reset();
          need_start = 1;
          return;
        end
      end
      if (mw >= TMO) begin halt_cycles(op); return; end
      e = E(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (cls == 5);
      if (cls == 5) begin
        e.pc_we = 1'b1;
        cyc(1'b0, run_after, op, rb(), 1'b1, e);
        exp_ret++;
      end else begin
        cyc(1'b0, rb(), op, rb(), 1'b1, e);
      end
    end
    if (cls != 3 && cls != 5) begin
      e = E(3'd5); e.reg_we = 1'b1; e.pc_we = 1'b1; e.pc_sel = (cls == 2);
      e.wb_sel = (cls == 4) ? 2'b01 : (cls == 2) ? 2'b10 : 2'b00;
      cyc(1'b0, run_after, op, rb(), rb(), e);
      exp_ret++;
    end
    if (!run_after) begin
      for (int i = 0; i < idle_n; i++) cyc(1'b0, 1'b0, op, rb(), rb(), E(3'd0));
      cyc(1'b0, 1'b1, op, rb(), rb(), E(3'd0));
    end
  endtask

  // Monitor: one expected entry per cycle, plus the two enable invariants.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we,
             wb_sel, busy, fault, instret};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got st=%0d en=%b wb=%b busy=%b fault=%b ret=%0d required st=%0d en=%b wb=%b busy=%b fault=%b ret=%0d",
                   $time, a.st, {a.mem_req, a.mem_we, a.addr_sel, a.ir_we, a.pc_we, a.pc_sel, a.reg_we},
                   a.wb_sel, a.busy, a.fault, a.ret, e.st,
                   {e.mem_req, e.mem_we, e.addr_sel, e.ir_we, e.pc_we, e.pc_sel, e.reg_we},
                   e.wb_sel, e.busy, e.fault, e.ret);
        end
        n_chk++;
        if (mem_we && !addr_sel) begin
          n_fail++;
          $display("FAIL we_addr t=%0t got mem_we=1 addr_sel=0 required not both", $time);
        end
        n_chk++;
        if (pc_we && ir_we) begin
          n_fail++;
          $display("FAIL pc_ir t=%0t got pc_we=1 ir_we=1 required not both", $time);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog got timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int pick, fw, mw;
    logic [6:0] op;
    // Reset state, then directed cases.
    do_reset();
    start();
    instr(7'b0010011, 0, 0, 1'b0, 1'b1, 0, 0);
    instr(7'b0000011, 0, 3, 1'b0, 1'b1, 0, 0);
    instr(7'b1100011, 0, 0, 1'b1, 1'b1, 0, 0);
    instr(7'b1100011, 0, 0, 1'b0, 1'b1, 0, 0);
    instr(7'b1101111, 1, 0, 1'b0, 1'b1, 0, 0);
    instr(7'b0100011, 0, 2, 1'b0, 1'b0, 2, 0);
    for (int i = 0; i < 18; i++) instr(7'b0110011, i % TMO, 0, 1'b0, 1'b1, 0, 0);
    instr(7'b1111111, 0, 0, 1'b0, 1'b1, 0, 0);
    recover();
    instr(7'b0010011, TMO, 0, 1'b0, 1'b1, 0, 0);
    recover();
    instr(7'b0010011, TMO - 1, 0, 1'b0, 1'b1, 0, 0);
    instr(7'b0000011, 0, TMO, 1'b0, 1'b1, 0, 0);
    recover();
    instr(7'b0100011, 0, TMO - 1, 1'b0, 1'b1, 0, 0);
    instr(7'b0010011, 0, 0, 1'b0, 1'b1, 0, 0);
    instr(7'b0000011, 0, 2, 1'b0, 1'b1, 0, 1);
    recover();
    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 39);
      if (pick == 0) op = 7'($urandom);
      else           op = legal_ops[pick % 6];
      fw = ($urandom_range(0, 39) == 0) ? TMO : $urandom_range(0, TMO - 1);
      mw = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, TMO - 1);
      instr(op, fw, mw, rb(), ($urandom_range(0, 3) != 0), $urandom_range(0, 2),
            ($urandom_range(0, 49) == 0));
      recover();
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d entries required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
